// File: rtl/oam_dma_pkg.sv
// rtl/oam_dma_pkg.sv - shared constants, FSM encoding and echo-fold helper for the OAM DMA block
package oam_dma_pkg;

    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam int          OAM_LEN_DFLT = 160;
    localparam logic [15:0] FF46_ADDR    = 16'hFF46;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } dma_state_t;

    // Sources in E0..FF are echo RAM; the bus sees them folded down onto C0..DF.
    function automatic logic [7:0] fold_hi(input logic [7:0] hi, input logic en);
        return (en && (hi[7:5] == 3'b111)) ? (hi & 8'hDF) : hi;
    endfunction

endpackage

// File: rtl/dma_start_pipe.sv
// rtl/dma_start_pipe.sv - FF46 write-to-start countdown; a newer write restarts the count
module dma_start_pipe #(
    parameter int START_DELAY = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_wr,
    input  logic [7:0] i_d,
    output logic [7:0] o_pend_hi,
    output logic       o_fire
);

    logic [7:0] r_pend_hi;
    logic [7:0] r_cnt;
    logic       r_pending;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend_hi <= 8'h00;
            r_cnt     <= 8'h00;
            r_pending <= 1'b0;
        end else if (i_wr) begin
            r_pend_hi <= i_d;
            r_cnt     <= 8'(START_DELAY - 1);
            r_pending <= 1'b1;
        end else if (r_pending) begin
            if (r_cnt == 8'd0) begin
                r_pending <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    // A write landing on the would-be firing edge wins: only the latest write starts a copy.
    assign o_fire    = r_pending && (r_cnt == 8'd0) && !i_wr;
    assign o_pend_hi = r_pend_hi;

endmodule

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - FF46 register and 160-byte source-page to OAM copy sequencer
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter int OAM_LEN     = OAM_LEN_DFLT,
    parameter int START_DELAY = 2,
    parameter int ECHO_FOLD   = 1
) (
    input  logic        boga1mhz,
    input  logic        nreset2,
    input  logic        ff46_wr,
    input  logic        ff46_rd,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    output logic        d_oe,
    output logic [15:0] dma_src_addr,
    input  logic [7:0]  dma_src_data,
    output logic        dma_bus_req,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    output logic        dma_active
);

    localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);
    localparam logic       FOLD_EN  = (ECHO_FOLD != 0);

    logic [7:0]  r_ff46;
    dma_state_t  r_state;
    logic [7:0]  r_rd_idx;
    logic [7:0]  r_src_hi;
    logic [15:0] r_src_addr;
    logic        r_bus_req;
    logic        r_active;
    logic [7:0]  r_oam_addr;
    logic [7:0]  r_oam_wdata;
    logic        r_oam_we;

    logic        w_fire;
    logic [7:0]  w_pend_hi;
    logic [7:0]  w_pend_bus_hi;
    logic [7:0]  w_next_idx;

    always_ff @(posedge boga1mhz or negedge nreset2) begin
        if (!nreset2) begin
            r_ff46 <= 8'h00;
        end else if (ff46_wr) begin
            r_ff46 <= d_in;
        end
    end

    dma_start_pipe #(
        .START_DELAY(START_DELAY)
    ) u_start_pipe (
        .i_clk    (boga1mhz),
        .i_rst_n  (nreset2),
        .i_wr     (ff46_wr),
        .i_d      (d_in),
        .o_pend_hi(w_pend_hi),
        .o_fire   (w_fire)
    );

    assign w_pend_bus_hi = fold_hi(w_pend_hi, FOLD_EN);
    assign w_next_idx    = r_rd_idx + 8'd1;

    // The capture runs on every RUN edge, even the one where a restart fires,
    // so the old transfer's last fetched byte still reaches OAM.
    always_ff @(posedge boga1mhz or negedge nreset2) begin
        if (!nreset2) begin
            r_state     <= ST_IDLE;
            r_rd_idx    <= 8'h00;
            r_src_hi    <= 8'h00;
            r_src_addr  <= 16'h0000;
            r_bus_req   <= 1'b0;
            r_active    <= 1'b0;
            r_oam_addr  <= 8'h00;
            r_oam_wdata <= 8'h00;
            r_oam_we    <= 1'b0;
        end else begin
            r_oam_we <= 1'b0;
            if (r_state == ST_RUN) begin
                r_oam_wdata <= dma_src_data;
                r_oam_addr  <= r_rd_idx;
                r_oam_we    <= 1'b1;
            end

            if (w_fire) begin
                r_state    <= ST_RUN;
                r_rd_idx   <= 8'h00;
                r_src_hi   <= w_pend_bus_hi;
                r_src_addr <= {w_pend_bus_hi, 8'h00};
                r_bus_req  <= 1'b1;
                r_active   <= 1'b1;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (r_rd_idx == LAST_IDX) begin
                            r_state    <= ST_DRAIN;
                            r_src_addr <= 16'h0000;
                            r_bus_req  <= 1'b0;
                        end else begin
                            r_rd_idx   <= w_next_idx;
                            r_src_addr <= {r_src_hi, w_next_idx};
                        end
                    end
                    ST_DRAIN: begin
                        r_state  <= ST_IDLE;
                        r_active <= 1'b0;
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_bus_req <= 1'b0;
                        r_active  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign d_out        = r_ff46;
    assign d_oe         = ff46_rd;
    assign dma_src_addr = r_src_addr;
    assign dma_bus_req  = r_bus_req;
    assign dma_active   = r_active;
    assign oam_addr     = r_oam_addr;
    assign oam_wdata    = r_oam_wdata;
    assign oam_we       = r_oam_we;

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - scoreboard bench for oam_dma against a per-cycle transfer schedule model
module tb_oam_dma;

    localparam int OAM_LEN = 160;
    localparam int SD      = 2;

    logic        boga1mhz = 1'b0;
    logic        nreset2  = 1'b0;
    logic        ff46_wr  = 1'b0;
    logic        ff46_rd  = 1'b0;
    logic [7:0]  d_in     = 8'h00;
    logic [7:0]  d_out;
    logic        d_oe;
    logic [15:0] dma_src_addr;
    logic [7:0]  dma_src_data;
    logic        dma_bus_req;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_we;
    logic        dma_active;
    logic [7:0]  salt = 8'h00;

    oam_dma #(.OAM_LEN(OAM_LEN), .START_DELAY(SD), .ECHO_FOLD(1)) dut (
        .boga1mhz    (boga1mhz),
        .nreset2     (nreset2),
        .ff46_wr     (ff46_wr),
        .ff46_rd     (ff46_rd),
        .d_in        (d_in),
        .d_out       (d_out),
        .d_oe        (d_oe),
        .dma_src_addr(dma_src_addr),
        .dma_src_data(dma_src_data),
        .dma_bus_req (dma_bus_req),
        .oam_addr    (oam_addr),
        .oam_wdata   (oam_wdata),
        .oam_we      (oam_we),
        .dma_active  (dma_active)
    );

    always #5 boga1mhz = ~boga1mhz;

    // Source memory: each byte is its low address byte, optionally scrambled by salt.
    assign dma_src_data = dma_src_addr[7:0] ^ salt;

    typedef struct packed {
        logic        act;
        logic        req;
        logic        we;
        logic        doe;
        logic [15:0] src;
        logic [7:0]  ff46;
    } st_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    st_t        st_q[$];
    wr_t        wq[$];
    int         wr_edge[$];
    logic [7:0] wr_val[$];
    int         cyc      = 0;
    int         n_checks = 0;
    int         n_pass   = 0;
    bit         mon_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at cycle %0d", name, got, exp, cyc);
    endtask

    function automatic logic [7:0] bus_page(input logic [7:0] p);
        if (p >= 8'hE0) return p - 8'h20;
        return p;
    endfunction

    // Edge of the most recent start that has fired by edge c (a write fires SD edges
    // later unless another write arrives in the meantime), or -1.
    function automatic int latest_fire(input int c, output logic [7:0] page);
        int best;
        best = -1;
        page = 8'h00;
        for (int i = 0; i < wr_edge.size(); i++) begin
            int f;
            bit cancelled;
            f = wr_edge[i] + SD;
            cancelled = (i + 1 < wr_edge.size()) && (wr_edge[i + 1] <= f);
            if (!cancelled && f <= c && f > best) begin
                best = f;
                page = wr_val[i];
            end
        end
        return best;
    endfunction

    task automatic push_expected();
        st_t        s;
        wr_t        w;
        logic [7:0] pg;
        int         f;
        int         k;
        s = '0;
        f = latest_fire(cyc, pg);
        if (f >= 0 && cyc - f <= OAM_LEN) s.act = 1'b1;
        if (f >= 0 && cyc - f <= OAM_LEN - 1) begin
            s.req = 1'b1;
            s.src = {bus_page(pg), 8'(cyc - f)};
        end
        f = latest_fire(cyc - 1, pg);
        if (f >= 0 && cyc - 1 - f <= OAM_LEN - 1) begin
            k      = cyc - 1 - f;
            s.we   = 1'b1;
            w.addr = 8'(k);
            w.data = 8'(k) ^ salt;
            wq.push_back(w);
        end
        for (int i = 0; i < wr_edge.size(); i++)
            if (wr_edge[i] <= cyc) s.ff46 = wr_val[i];
        s.doe = ff46_rd;
        st_q.push_back(s);
    endtask

    task automatic step();
        @(posedge boga1mhz);
        cyc++;
        #1;
        ff46_wr = 1'b0;
        d_in    = 8'($urandom);
        ff46_rd = 1'($urandom_range(0, 1));
        push_expected();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input logic [7:0] v);
        ff46_wr = 1'b1;
        d_in    = v;
        wr_edge.push_back(cyc + 1);
        wr_val.push_back(v);
    endtask

    task automatic check_all_zero();
        chk("rst_active", 32'(dma_active), 32'd0);
        chk("rst_bus_req", 32'(dma_bus_req), 32'd0);
        chk("rst_src_addr", 32'(dma_src_addr), 32'd0);
        chk("rst_oam_we", 32'(oam_we), 32'd0);
        chk("rst_oam_addr", 32'(oam_addr), 32'd0);
        chk("rst_oam_wdata", 32'(oam_wdata), 32'd0);
        chk("rst_d_out", 32'(d_out), 32'd0);
        chk("rst_d_oe", 32'(d_oe), 32'd0);
    endtask

    task automatic release_reset();
        @(posedge boga1mhz);
        cyc++;
        #1;
        nreset2 = 1'b1;
        ff46_rd = 1'($urandom_range(0, 1));
        push_expected();
        mon_en = 1'b1;
    endtask

    task automatic do_reset();
        #2;
        mon_en  = 1'b0;
        ff46_rd = 1'b0;
        ff46_wr = 1'b0;
        nreset2 = 1'b0;
        #1;
        check_all_zero();
        st_q.delete();
        wq.delete();
        wr_edge.delete();
        wr_val.delete();
        @(posedge boga1mhz);
        cyc++;
        release_reset();
    endtask

    initial begin : monitor
        st_t s;
        wr_t w;
        forever begin
            @(negedge boga1mhz);
            if (mon_en) begin
                chk("status_avail", 32'(st_q.size() != 0), 32'd1);
                if (st_q.size() != 0) begin
                    s = st_q.pop_front();
                    chk("dma_active", 32'(dma_active), 32'(s.act));
                    chk("dma_bus_req", 32'(dma_bus_req), 32'(s.req));
                    chk("dma_src_addr", 32'(dma_src_addr), 32'(s.src));
                    chk("oam_we", 32'(oam_we), 32'(s.we));
                    chk("d_out", 32'(d_out), 32'(s.ff46));
                    chk("d_oe", 32'(d_oe), 32'(s.doe));
                end
                if (oam_we === 1'b1) begin
                    chk("oam_write_expected", 32'(wq.size() != 0), 32'd1);
                    if (wq.size() != 0) begin
                        w = wq.pop_front();
                        chk("oam_addr", 32'(oam_addr), 32'(w.addr));
                        chk("oam_wdata", 32'(oam_wdata), 32'(w.data));
                    end
                end
            end
        end
    end

    initial begin : stim
        repeat (2) @(posedge boga1mhz);
        cyc = 2;
        #1;
        check_all_zero();
        release_reset();

        salt = 8'h00;
        run(3);
        wr(8'hC1);
        run(175);

        salt = 8'($urandom);
        wr(8'hE3);
        run(175);

        wr(8'h80);
        run(SD + 50);
        wr(8'h90);
        run(175);

        wr(8'hA0);
        step();
        wr(8'hB0);
        run(175);

        wr(8'h5A);
        run(SD + 78);
        do_reset();
        run(20);

        repeat (2500) begin
            step();
            if ($urandom_range(0, 99) < 3) wr(8'($urandom));
        end
        run(180);

        chk("oam_writes_drained", 32'(wq.size()), 32'd0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
